// File: rtl/vec_alu_pkg.sv
// Shared opcode, flag-index and stage payload definitions for vec_alu_pipe.
// The optional multiplier is enabled by defining VEC_ALU_PIPE_MUL_EN.
package vec_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_ORR   = 4'd3,
    OP_EOR   = 4'd4,
    OP_MOV   = 4'd5,
    OP_ADDSU = 4'd6,
    OP_SUBSU = 4'd7,
    OP_MUL   = 4'd8
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int DEF_LANES  = 4;
  localparam int DEF_LANE_W = 8;
  localparam int DEF_TAG_W  = 4;

  // Payload at the default geometry; the top rebuilds it from its own parameters.
  typedef struct packed {
    logic [DEF_LANES*DEF_LANE_W-1:0] result;
    logic [DEF_LANES*4-1:0]          flags;
    logic [DEF_TAG_W-1:0]            tag;
    logic                            illegal;
  } stage_t;

endpackage

// File: rtl/vec_alu_lane.sv
// Single-lane combinational ALU producing result, NZCV and illegal.
// Opcode 8 is MUL only when VEC_ALU_PIPE_MUL_EN is defined.
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic [3:0]   nzcv,
  output logic         illegal
);

  logic [W:0] sum;
  logic [W:0] diff;
  logic       c;
  logic       v;

`ifdef VEC_ALU_PIPE_MUL_EN
  logic [2*W-1:0] prod;
  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result  = '0;
    c       = 1'b0;
    v       = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[W-1:0];
        c      = sum[W];
        v      = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
      end
      OP_SUB: begin
        result = diff[W-1:0];
        c      = ~diff[W];
        v      = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]);
      end
      OP_AND: result = a & b;
      OP_ORR: result = a | b;
      OP_EOR: result = a ^ b;
      OP_MOV: result = b;
      OP_ADDSU: begin
        c      = sum[W];
        result = sum[W] ? '1 : sum[W-1:0];
      end
      OP_SUBSU: begin
        c      = diff[W];
        result = diff[W] ? '0 : diff[W-1:0];
      end
`ifdef VEC_ALU_PIPE_MUL_EN
      OP_MUL: begin
        result = prod[W-1:0];
        c      = |prod[2*W-1:W];
      end
`endif
      default: illegal = 1'b1;
    endcase
    nzcv = '0;
    if (!illegal) begin
      nzcv[FLAG_N] = result[W-1];
      nzcv[FLAG_Z] = ~|result;
      nzcv[FLAG_C] = c;
      nzcv[FLAG_V] = v;
    end
  end

endmodule

// File: rtl/vec_alu_pipe.sv
// Multi-lane SIMD execute pipeline with elastic valid/ready stages and flush.
// Define VEC_ALU_PIPE_MUL_EN to add the per-lane MUL opcode.
module vec_alu_pipe
  import vec_alu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int DEPTH  = 3,
  parameter int TAG_W  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_op,
  input  logic [LANES*LANE_W-1:0]    in_a,
  input  logic [LANES*LANE_W-1:0]    in_b,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*LANE_W-1:0]    out_result,
  output logic [LANES*4-1:0]         out_flags,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int DW = LANES * LANE_W;
  localparam int OW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0]        result;
    logic [LANES*4-1:0]   flags;
    logic [TAG_W-1:0]     tag;
    logic                 illegal;
  } pay_t;

  pay_t               st [DEPTH];
  pay_t               head;
  logic [DEPTH-1:0]   vld;
  logic [DEPTH-1:0]   load;
  logic [DW-1:0]      lane_res;
  logic [LANES*4-1:0] lane_flg;
  logic [LANES-1:0]   lane_ill;
  logic [OW-1:0]      occ;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vec_alu_lane #(.W(LANE_W)) u_lane (
      .op      (op_e'(in_op)),
      .a       (in_a[g*LANE_W +: LANE_W]),
      .b       (in_b[g*LANE_W +: LANE_W]),
      .result  (lane_res[g*LANE_W +: LANE_W]),
      .nzcv    (lane_flg[g*4 +: 4]),
      .illegal (lane_ill[g])
    );
  end

  always_comb begin
    head = '{
      result:  lane_res,
      flags:   lane_flg,
      tag:     in_tag,
      illegal: |lane_ill
    };
  end

  // A stage may load when it is empty or everything below it can move.
  always_comb begin
    logic nxt;
    nxt = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      nxt     = !vld[k] || nxt;
      load[k] = nxt;
    end
  end

  assign in_ready = !flush && load[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) st[k] <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (load[0]) begin
        vld[0] <= in_valid;
        if (in_valid) st[0] <= head;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) st[k] <= st[k-1];
        end
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) occ = occ + OW'(vld[k]);
  end

  assign occupancy   = occ;
  assign out_valid   = vld[DEPTH-1];
  assign out_result  = st[DEPTH-1].result;
  assign out_flags   = st[DEPTH-1].flags;
  assign out_tag     = st[DEPTH-1].tag;
  assign out_illegal = st[DEPTH-1].illegal;

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Scoreboard bench for vec_alu_pipe at default parameters.
// Build with VEC_ALU_PIPE_MUL_EN to exercise the MUL opcode.
module tb_vec_alu_pipe;

  localparam int LANES = 4;
  localparam int W     = 8;
  localparam int DEPTH = 3;
  localparam int TAG_W = 4;
  localparam int DW    = LANES * W;
  localparam int M     = 1 << W;
  localparam int H     = M / 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_result;
  logic [15:0]      out_flags;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [1:0]       occupancy;

  typedef struct packed {
    logic [DW-1:0]    res;
    logic [15:0]      flg;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  exp_t mon_g;
  int   checks    = 0;
  int   errors    = 0;
  int   delivered = 0;
  bit   done;

  always #5 clk = ~clk;

  vec_alu_pipe #(
    .LANES(LANES), .LANE_W(W), .DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .out_tag(out_tag), .out_illegal(out_illegal),
    .occupancy(occupancy)
  );

  function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [TAG_W-1:0] tag);
    exp_t e;
    int ua, ub, r, sa, sb, sr;
    bit c, v, ill;
    logic [3:0] f;
    e = '0;
    e.tag = tag;
    for (int i = 0; i < LANES; i++) begin
      ua = int'(a[i*W +: W]);
      ub = int'(b[i*W +: W]);
      sa = (ua >= H) ? ua - M : ua;
      sb = (ub >= H) ? ub - M : ub;
      r = 0; c = 0; v = 0; ill = 0;
      case (op)
        4'd0: begin
          r = ua + ub; c = (r >= M); r = r % M;
          sr = sa + sb; v = (sr < -H) || (sr >= H);
        end
        4'd1: begin
          r = (ua - ub + M) % M; c = (ua >= ub);
          sr = sa - sb; v = (sr < -H) || (sr >= H);
        end
        4'd2: r = ua & ub;
        4'd3: r = ua | ub;
        4'd4: r = ua ^ ub;
        4'd5: r = ub;
        4'd6: begin
          r = ua + ub; c = (r > M - 1); if (c) r = M - 1;
        end
        4'd7: begin
          c = (ub > ua); r = c ? 0 : ua - ub;
        end
        4'd8: begin
`ifdef VEC_ALU_PIPE_MUL_EN
          r = ua * ub; c = (r >= M); r = r % M;
`else
          ill = 1;
`endif
        end
        default: ill = 1;
      endcase
      f = ill ? 4'b0000 : {r >= H, r == 0, c, v};
      e.res[i*W +: W] = r[W-1:0];
      e.flg[i*4 +: 4] = f;
      if (ill) e.ill = 1'b1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      delivered++;
      mon_g = '{out_result, out_flags, out_tag, out_illegal};
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got tag=%0d required no output", out_tag);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_g !== mon_e) begin
          errors++;
          $display("FAIL sb_result got %h required %h", mon_g, mon_e);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [TAG_W-1:0] tag);
    int n;
    bit ok;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    n = 0; ok = 0;
    while (!ok && n < 60) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout got in_ready=0 required 1 tag=%0d", tag);
    end else begin
      sbq.push_back(model(op, a, b, tag));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [TAG_W-1:0] tag);
    out_ready = 1'b1;
    send(op, a, b, tag);
    repeat (DEPTH - 1) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", sbq.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); in_op = 4'($urandom); in_a = $urandom;
      in_b = $urandom; in_tag = 4'($urandom); flush = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL reset_valid got v=%b occ=%0d required 0 0", out_valid, occupancy);
      end
      checks++;
      if (out_result !== '0 || out_flags !== '0 || out_tag !== '0 || out_illegal !== 1'b0) begin
        errors++;
        $display("FAIL reset_data got %h %h %h %b required zeros",
                 out_result, out_flags, out_tag, out_illegal);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    send(4'd0, 32'h7FFF0180, 32'h01010180, 4'd3);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL add_lat1 got %b required 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL add_lat2 got %b required 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h80000200 || out_tag !== 4'd3) begin
      errors++;
      $display("FAIL add_result got v=%b %h tag=%0d required 1 80000200 3",
               out_valid, out_result, out_tag);
    end
    checks++;
    if (out_flags !== 16'h9607 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL add_flags got %h ill=%b required 9607 0", out_flags, out_illegal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lane_ops();
    run_op(4'd1, {24'($urandom), 8'h05}, {24'($urandom), 8'h09}, 4'd5);
    checks++;
    if (out_result[7:0] !== 8'hFC || out_flags[3:0] !== 4'b1000) begin
      errors++;
      $display("FAIL sub got %h/%b required fc/1000", out_result[7:0], out_flags[3:0]);
    end
    run_op(4'd7, {24'($urandom), 8'h05}, {24'($urandom), 8'h09}, 4'd6);
    checks++;
    if (out_result[7:0] !== 8'h00 || out_flags[3:0] !== 4'b0110) begin
      errors++;
      $display("FAIL subsu got %h/%b required 00/0110", out_result[7:0], out_flags[3:0]);
    end
    run_op(4'd6, {24'($urandom), 8'hF0}, {24'($urandom), 8'h20}, 4'd7);
    checks++;
    if (out_result[7:0] !== 8'hFF || out_flags[3:0] !== 4'b1010) begin
      errors++;
      $display("FAIL addsu got %h/%b required ff/1010", out_result[7:0], out_flags[3:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc, d0, n;
    bit ok;
    out_ready = 1'b0; acc = 0; d0 = delivered; n = 0;
    in_valid = 1'b1;
    while (n < 6 || (acc < 5 && n < 30)) begin
      if (n == 6) begin
        checks++;
        if (acc != 3 || in_ready !== 1'b0 || occupancy !== 2'd3) begin
          errors++;
          $display("FAIL b2b_full got acc=%0d rdy=%b occ=%0d required 3 0 3",
                   acc, in_ready, occupancy);
        end
        out_ready = 1'b1;
      end
      in_op = 4'd2; in_a = {4{8'(acc * 37 + 5)}}; in_b = {4{8'(acc * 11 + 3)}};
      in_tag = 4'(acc);
      @(negedge clk);
      ok = in_ready && acc < 5;
      if (ok) sbq.push_back(model(in_op, in_a, in_b, in_tag));
      @(posedge clk); #1;
      if (ok) acc++;
      if (acc >= 5) in_valid = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (delivered - d0 != 5) begin
      errors++;
      $display("FAIL b2b_count got %0d required 5", delivered - d0);
    end
  endtask

  task automatic test_random();
    done = 0;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(4'($urandom_range(0, 15)), $urandom, $urandom, 4'(i));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
  endtask

  task automatic test_flush();
    int cnt;
    out_ready = 1'b0;
    send(4'd0, $urandom, $urandom, 4'd1);
    send(4'd4, $urandom, $urandom, 4'd2);
    send(4'd5, $urandom, $urandom, 4'd3);
    checks++;
    if (occupancy !== 2'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_fill got occ=%0d v=%b required 3 1", occupancy, out_valid);
    end
    in_valid = 1'b1; in_op = 4'd0; in_tag = 4'hA; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got %b required 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_clear got v=%b occ=%0d required 0 0", out_valid, occupancy);
    end
    sbq.delete();
    out_ready = 1'b1; cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++; $display("FAIL flush_ghost got %0d outputs required 0", cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    run_op(4'hF, $urandom, $urandom, 4'd9);
    checks++;
    if (out_result !== '0 || out_flags !== '0 || out_illegal !== 1'b1) begin
      errors++;
      $display("FAIL op15 got %h %h %b required 0 0 1", out_result, out_flags, out_illegal);
    end
    run_op(4'd8, {24'($urandom), 8'h10}, {24'($urandom), 8'h11}, 4'd10);
`ifdef VEC_ALU_PIPE_MUL_EN
    checks++;
    if (out_result[7:0] !== 8'h10 || out_flags[3:0] !== 4'b0010 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL mul got %h/%b ill=%b required 10/0010 0",
               out_result[7:0], out_flags[3:0], out_illegal);
    end
`else
    checks++;
    if (out_result !== '0 || out_flags !== '0 || out_illegal !== 1'b1) begin
      errors++;
      $display("FAIL op8 got %h %h %b required 0 0 1", out_result, out_flags, out_illegal);
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_add();
    test_lane_ops();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_alu_pipe.md
Name: vec_alu_pipe

Overview:
Parametrised multi-lane SIMD execute pipeline. It is the next-generation execute stage for the core: LANES independent ALU lanes, each LANE_W bits wide, behind an elastic pipeline of DEPTH register stages. The pipeline uses a valid/ready handshake, stalls on backpressure and supports a synchronous flush. It sits between the decode/issue register and the memory/writeback path, and produces per-lane NZCV flags for the conditional unit.

Parameters:
LANES, 4, number of parallel lanes (>=1)
LANE_W, 8, bits per lane (>=2)
DEPTH, 3, pipeline register stages from input accept to output (>=1)
TAG_W, 4, width of the sideband tag carried with each operation

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operation offered
in_ready  out  1  operation accepted when in_valid && in_ready
in_op  in  4  opcode (see Behaviour)
in_a  in  LANES*LANE_W  operand A; lane i = bits [i*LANE_W +: LANE_W]
in_b  in  LANES*LANE_W  operand B
in_tag  in  TAG_W  sideband tag; returned unchanged
flush  in  1  synchronous kill of all in-flight operations
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  LANES*LANE_W  per-lane result
out_flags  out  LANES*4  per-lane {N,Z,C,V}; lane i = bits [i*4 +: 4]
out_tag  out  TAG_W  tag of the presented result
out_illegal  out  1  presented operation had a reserved opcode
occupancy  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset (reset low, asynchronous): all stage valid bits and data registers clear to 0; out_valid=0, out_result=0, out_flags=0, out_tag=0, out_illegal=0, occupancy=0; in_ready=1 once reset is released.
- Opcodes:
  - 0 ADD, 1 SUB (a-b), 2 AND, 3 ORR, 4 EOR, 5 MOV (result=b).
  - 6 ADDSU: unsigned saturating add, clamps to all-ones.
  - 7 SUBSU: unsigned saturating sub, clamps to 0.
  - 8-15 reserved: result=0, flags=0, illegal=1.
- Lane computation is combinational on the accepted operands and is captured into stage 1. Stages 2..DEPTH only delay the data. The output registers are stage DEPTH.
- Latency: exactly DEPTH cycles from the accept edge to out_valid, with no backpressure. Throughput is 1 operation per cycle.
- Flags (ARM convention):
  - N = result MSB; Z = (result==0).
  - ADD: C = carry-out. SUB: C = NOT borrow. V = signed overflow for ADD and SUB.
  - Logic ops and MOV: C=0, V=0.
  - Saturating ops: C=1 when saturation occurred, V=0.
- Elastic advance:
  - Stage k loads from stage k-1 when stage k is empty, or when stage k is advancing.
  - The last stage advances on out_ready.
  - in_ready = !flush && (stage 1 empty || stage 1 advancing).
  - A bubble never blocks an upstream valid entry.
- Output: out_* hold stable while out_valid && !out_ready. No loss, no duplication, strict in-order delivery.
- flush:
  - The next edge clears all valid bits and occupancy.
  - flush with in_valid in the same cycle: the input is not accepted.
  - flush with out_valid && out_ready in the same cycle: that result counts as delivered and the rest is discarded.
- occupancy counts the valid stages. When the pipe is full and out_ready=0, in_ready=0.

Optional Feature:
Macro VEC_ALU_PIPE_MUL_EN.
- Defined: opcode 8 = MUL, giving the low LANE_W bits of the unsigned per-lane product. N and Z are set from the result; C = (high half != 0); V=0. Latency is unchanged at DEPTH.
- Undefined: opcode 8 is reserved (result 0, flags 0, out_illegal=1), and no multiplier logic is synthesised.

Decomposition:
- Package vec_alu_pkg holds:
  - the op_e enum (4-bit) with all opcode constants;
  - flag bit index localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - a stage payload struct type generated from the parameters.
- Sub-module vec_alu_lane: purely combinational single-lane ALU (op, a, b -> result, nzcv, illegal). It is instantiated LANES times in a generate loop.
- The top level holds the elastic stage registers, the handshake logic and occupancy.

Test Plan:
1. Hold reset low for 3 cycles with random inputs -> out_valid=0, occupancy=0, all outputs 0. After release, in_ready=1.
2. ADD, defaults, a=0x7FFF0180, b=0x01010180, tag=3, out_ready=1 -> exactly 3 cycles later:
   - out_result=0x80000200, out_tag=3;
   - lane0 Z=1 C=1 V=1; lane1 all flags 0; lane2 Z=1 C=1; lane3 N=1 V=1.
3. Lane0 with a=0x05, b=0x09:
   - SUB -> 0xFC, N=1, C=0.
   - SUBSU -> 0x00, Z=1, C=1.
   - ADDSU with a=0xF0, b=0x20 -> 0xFF, C=1.
4. Issue 5 back-to-back operations with tags 0..4 while out_ready=0 -> in_ready drops after 3 accepts and occupancy=3. Raise out_ready -> tags 0,1,2,3,4 delivered in order, none lost or duplicated.
5. Pipe full, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, and the offered operation does not appear later.
6. in_op=0xF (and op 8 without VEC_ALU_PIPE_MUL_EN) -> out_result=0, out_flags=0, out_illegal=1. With the macro defined, op 8 on lane 0x10*0x11 -> 0x10, C=1.
